// File: rtl/act_feedback_buffer.sv
// act_feedback_buffer: collects one layer's activations, then replays them in order as the next layer's input.
module act_feedback_buffer #(
  parameter int DWIDTH = 32,
  parameter int NNEURON = 10,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              act_valid,
  input  logic [DWIDTH-1:0] act_data,
  output logic              act_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic              sel,
  output logic [AWIDTH-1:0] fill_cnt
);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state;
  logic [AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [DWIDTH-1:0] mem [NNEURON];
  logic wr, rd, last_wr;
  assign act_ready = state == FILL;
  assign out_valid = state == DRAIN;
  assign sel = out_valid;
  assign wr = act_ready && act_valid;
  assign rd = out_valid && out_ready;
  assign last_wr = wr_ptr == AWIDTH'(NNEURON - 1);
  assign out_last = out_valid && rd_ptr == AWIDTH'(NNEURON - 1);
  assign out_data = out_valid ? mem[rd_ptr] : '0;
  assign fill_cnt = out_valid ? AWIDTH'(NNEURON) : wr_ptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      state <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (wr) begin
      wr_ptr <= last_wr ? '0 : wr_ptr + 1'b1;
      rd_ptr <= '0;
      state <= last_wr ? DRAIN : FILL;
    end else if (rd) begin
      rd_ptr <= out_last ? '0 : rd_ptr + 1'b1;
      state <= out_last ? FILL : DRAIN;
    end
  always_ff @(posedge clk)
    if (wr && !clr) mem[wr_ptr] <= act_data;
endmodule

// File: tb/tb_act_feedback_buffer.sv
// tb_act_feedback_buffer: directed scoreboard bench for act_feedback_buffer.
module tb_act_feedback_buffer;
  localparam int DW = 32;
  localparam int NN = 10;
  localparam int AW = 4;
  logic clk = 0, rst = 1, clr = 0, act_valid = 0, out_ready = 0;
  logic [DW-1:0] act_data = '0;
  logic act_ready, out_valid, out_last, sel;
  logic [DW-1:0] out_data;
  logic [AW-1:0] fill_cnt;
  int checks = 0, errors = 0;
  logic [DW-1:0] q[$];
  bit m_fill = 1;

  always #5 clk = ~clk;

  act_feedback_buffer #(.DWIDTH(DW), .NNEURON(NN), .AWIDTH(AW)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .sel(sel), .fill_cnt(fill_cnt)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    logic [DW-1:0] exp_data;
    exp_data = '0;
    if (!m_fill) exp_data = q[0];
    chk("act_ready", DW'(act_ready), DW'(m_fill));
    chk("out_valid", DW'(out_valid), DW'(!m_fill));
    chk("sel", DW'(sel), DW'(!m_fill));
    chk("out_last", DW'(out_last), DW'(!m_fill && q.size() == 1));
    chk("fill_cnt", DW'(fill_cnt), m_fill ? DW'(q.size()) : DW'(NN));
    chk("out_data", out_data, exp_data);
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the scoreboard.
  task automatic cyc(input bit av, input logic [DW-1:0] ad, input bit ordy, input bit c);
    act_valid = av;
    act_data = ad;
    out_ready = ordy;
    clr = c;
    #3 check_outs();
    if (c) begin
      q.delete();
      m_fill = 1;
    end else if (m_fill && av) begin
      q.push_back(ad);
      if (q.size() == NN) m_fill = 0;
    end else if (!m_fill && ordy) begin
      void'(q.pop_front());
      if (q.size() == 0) m_fill = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    act_valid = 1;
    act_data = 32'h1234;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_act_ready", DW'(act_ready), DW'(1));
      chk("rst_out_valid", DW'(out_valid), DW'(0));
      chk("rst_sel", DW'(sel), DW'(0));
      chk("rst_fill_cnt", DW'(fill_cnt), DW'(0));
    end
    rst = 0;
    act_valid = 0;
    cyc(0, 0, 1, 0);
    // basic round trip
    for (int i = -5; i < 5; i++) cyc(1, DW'(i), 1, 0);
    for (int i = 0; i < NN + 2; i++) cyc(0, 0, 1, 0);
    // gapped input then backpressure at entry 3
    for (int i = 0; i < 20; i++) cyc(i % 2 == 0, DW'(100 + i), 0, 0);
    repeat (3) cyc(0, 0, 1, 0);
    repeat (5) cyc(0, 0, 0, 0);
    repeat (8) cyc(0, 0, 1, 0);
    // act_valid held through DRAIN
    for (int i = 0; i < NN; i++) cyc(1, DW'(200 + i), 1, 0);
    for (int i = 0; i < NN; i++) cyc(1, DW'(900 + i), 1, 0);
    for (int i = 0; i < NN; i++) cyc(1, DW'(300 + i), 1, 0);
    for (int i = 0; i < NN + 1; i++) cyc(0, 0, 1, 0);
    // clr mid-FILL
    for (int i = 0; i < 6; i++) cyc(1, DW'(-400 - i), 1, 0);
    cyc(1, DW'(777), 1, 1);
    for (int i = 0; i < NN; i++) cyc(1, DW'(500 + i), 0, 0);
    for (int i = 0; i < NN + 1; i++) cyc(0, 0, 1, 0);
    // clr mid-DRAIN at rd_ptr=4
    for (int i = 0; i < NN; i++) cyc(1, DW'(600 + i), 1, 0);
    repeat (4) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    repeat (2) cyc(0, 0, 1, 0);
    // async reset mid-DRAIN at rd_ptr=7
    for (int i = 0; i < NN; i++) cyc(1, DW'(32'h8000_0000 + i), 1, 0);
    repeat (7) cyc(0, 0, 1, 0);
    out_ready = 0;
    #2 rst = 1;
    #1;
    chk("arst_out_valid", DW'(out_valid), DW'(0));
    chk("arst_sel", DW'(sel), DW'(0));
    chk("arst_out_last", DW'(out_last), DW'(0));
    chk("arst_act_ready", DW'(act_ready), DW'(1));
    chk("arst_fill_cnt", DW'(fill_cnt), DW'(0));
    chk("arst_out_data", out_data, DW'(0));
    #1 rst = 0;
    q.delete();
    m_fill = 1;
    @(posedge clk);
    #1;
    cyc(0, 0, 1, 0);
    for (int i = 0; i < NN; i++) cyc(1, DW'(700 - i), 1, 0);
    for (int i = 0; i < NN + 1; i++) cyc(0, 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
